// File: rtl/instr_seq_pkg.sv
// Shared types for the instruction sequencer: opcode encoding, FSM states,
// and small decode helpers used by the control logic.
package instr_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_LD  = 4'd5,
        OP_ST  = 4'd6,
        OP_BZ  = 4'd7,
        OP_BNZ = 4'd8,
        OP_JMP = 4'd9
    } op_code_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;

    // True for any control-flow opcode, taken or not; these never write the register file.
    function automatic logic is_branch_op(input op_code_t op);
        case (op)
            OP_BZ, OP_BNZ, OP_JMP: is_branch_op = 1'b1;
            default:               is_branch_op = 1'b0;
        endcase
    endfunction

    // True for loads and stores, which detour through the MEM state.
    function automatic logic is_mem_op(input op_code_t op);
        case (op)
            OP_LD, OP_ST: is_mem_op = 1'b1;
            default:      is_mem_op = 1'b0;
        endcase
    endfunction

    // Resolves whether a control-flow opcode redirects the PC given the ALU zero flag.
    function automatic logic branch_taken(input op_code_t op, input logic zero);
        case (op)
            OP_BZ:   branch_taken = zero;
            OP_BNZ:  branch_taken = ~zero;
            OP_JMP:  branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_seq_pc_reg.sv
// Program counter register: clear, absolute load, or increment with natural
// modulo-2^PC_W wrap. Clear beats load, load beats increment.
module pc_reg #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            load,
    input  logic            incr,
    input  logic [PC_W-1:0] load_value,
    output logic [PC_W-1:0] pc
);

    // PC update; the increment is allowed to overflow back to zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_value;
        end else if (incr) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/instr_seq.sv
// Multi-cycle instruction sequencer: walks FETCH/EXEC per instruction, detours
// through MEM for loads/stores with a bounded wait, and parks in DONE on halt
// or memory timeout until restarted.
module instr_seq
    import instr_seq_pkg::*;
#(
    parameter int PC_W        = 10,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            start_i,
    input  logic [3:0]      op_i,
    input  logic            halt_i,
    input  logic            zero_i,
    input  logic [PC_W-1:0] target_i,
    input  logic            mem_ack_i,
    output logic [PC_W-1:0] pc_o,
    output logic            fetch_o,
    output logic            reg_we_o,
    output logic            mem_re_o,
    output logic            mem_we_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] wait_cnt;

    op_code_t op;
    logic     exec_go;
    logic     mem_ack_hit;
    logic     op_is_mem;
    logic     op_is_branch;
    logic     op_taken;
    logic     pc_clear;
    logic     pc_load;
    logic     pc_incr;

    assign op           = op_code_t'(op_i);
    assign op_is_mem    = is_mem_op(op);
    assign op_is_branch = is_branch_op(op);
    assign op_taken     = branch_taken(op, zero_i);

    // A halt in EXEC suppresses every opcode-driven side effect.
    assign exec_go     = (state == S_EXEC) && !halt_i;
    // Acks only count while a memory request is outstanding.
    assign mem_ack_hit = (state == S_MEM) && mem_ack_i;

    assign pc_clear = ((state == S_IDLE) || (state == S_DONE)) && start_i;
    assign pc_load  = exec_go && op_taken;
    assign pc_incr  = (exec_go && !op_is_mem && !op_taken) || mem_ack_hit;

    // Write-back happens in the cycle the result exists: EXEC for ALU ops, the ack cycle for loads.
    // mem_re_o doubles as the "this MEM visit is a load" marker.
    assign reg_we_o = (exec_go && !op_is_mem && !op_is_branch) || (mem_ack_hit && mem_re_o);

    pc_reg #(
        .PC_W(PC_W)
    ) u_pc (
        .clk        (CLK),
        .reset      (reset),
        .clear      (pc_clear),
        .load       (pc_load),
        .incr       (pc_incr),
        .load_value (target_i),
        .pc         (pc_o)
    );

    // Sequencer FSM with registered strobes, status flags and the memory wait counter.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            fetch_o  <= 1'b0;
            mem_re_o <= 1'b0;
            mem_we_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state   <= S_FETCH;
                        fetch_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    fetch_o <= 1'b0;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    if (halt_i) begin
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else if (op == OP_LD) begin
                        state    <= S_MEM;
                        mem_re_o <= 1'b1;
                        wait_cnt <= '0;
                    end else if (op == OP_ST) begin
                        state    <= S_MEM;
                        mem_we_o <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        state   <= S_FETCH;
                        fetch_o <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (mem_ack_i) begin
                        mem_re_o <= 1'b0;
                        mem_we_o <= 1'b0;
                        state    <= S_FETCH;
                        fetch_o  <= 1'b1;
                    end else if (wait_cnt == LAST_WAIT) begin
                        mem_re_o <= 1'b0;
                        mem_we_o <= 1'b0;
                        err_o    <= 1'b1;
                        done_o   <= 1'b1;
                        busy_o   <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (start_i) begin
                        done_o  <= 1'b0;
                        err_o   <= 1'b0;
                        state   <= S_FETCH;
                        fetch_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_seq.sv
// Bench for instr_seq: a per-cycle vector table run through an expected-value
// queue, followed by hand-written memory timeout and late-ack sequences.
module tb_instr_seq;
    import instr_seq_pkg::*;

    localparam int PC_W = 10;

    localparam logic [6:0] F_FETCH = 7'b1000000;
    localparam logic [6:0] F_WE    = 7'b0100000;
    localparam logic [6:0] F_RE    = 7'b0010000;
    localparam logic [6:0] F_WR    = 7'b0001000;
    localparam logic [6:0] F_BUSY  = 7'b0000100;
    localparam logic [6:0] F_DONE  = 7'b0000010;
    localparam logic [6:0] F_ERR   = 7'b0000001;

    typedef struct {
        logic            rst;
        logic            start;
        logic [3:0]      op;
        logic            halt;
        logic            zero;
        logic [PC_W-1:0] target;
        logic            ack;
        logic [PC_W-1:0] exp_pc;
        logic [6:0]      exp_flags;
    } vec_t;

    typedef struct {
        int              idx;
        logic [PC_W-1:0] pc;
        logic [6:0]      flags;
    } exp_t;

    logic            CLK;
    logic            reset;
    logic            start_i;
    logic [3:0]      op_i;
    logic            halt_i;
    logic            zero_i;
    logic [PC_W-1:0] target_i;
    logic            mem_ack_i;
    logic [PC_W-1:0] pc_o;
    logic            fetch_o;
    logic            reg_we_o;
    logic            mem_re_o;
    logic            mem_we_o;
    logic            busy_o;
    logic            done_o;
    logic            err_o;

    vec_t vecs[$];
    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    instr_seq #(
        .PC_W        (PC_W),
        .MEM_TIMEOUT (15)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .start_i   (start_i),
        .op_i      (op_i),
        .halt_i    (halt_i),
        .zero_i    (zero_i),
        .target_i  (target_i),
        .mem_ack_i (mem_ack_i),
        .pc_o      (pc_o),
        .fetch_o   (fetch_o),
        .reg_we_o  (reg_we_o),
        .mem_re_o  (mem_re_o),
        .mem_we_o  (mem_we_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void row(input logic r, input logic s, input op_code_t op, input logic h,
                                input logic z, input logic [PC_W-1:0] t, input logic a,
                                input logic [PC_W-1:0] pc, input logic [6:0] fl);
        vec_t v;
        v.rst = r; v.start = s; v.op = 4'(op); v.halt = h; v.zero = z;
        v.target = t; v.ack = a; v.exp_pc = pc; v.exp_flags = fl;
        vecs.push_back(v);
    endfunction

    function automatic logic [6:0] dutFlags();
        return {fetch_o, reg_we_o, mem_re_o, mem_we_o, busy_o, done_o, err_o};
    endfunction

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one vector on the falling edge and queue what the outputs must show this cycle.
    task automatic applyStimulus(input int idx);
        exp_t e;
        @(negedge CLK);
        reset     = vecs[idx].rst;
        start_i   = vecs[idx].start;
        op_i      = vecs[idx].op;
        halt_i    = vecs[idx].halt;
        zero_i    = vecs[idx].zero;
        target_i  = vecs[idx].target;
        mem_ack_i = vecs[idx].ack;
        e.idx = idx; e.pc = vecs[idx].exp_pc; e.flags = vecs[idx].exp_flags;
        expQ.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows mid-cycle.
    task automatic checkOutput();
        exp_t e;
        #2;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard empty");
            return;
        end
        e = expQ.pop_front();
        if (pc_o !== e.pc) begin
            errors++;
            $display("[TB] FAIL row %0d pc got %h expected %h", e.idx, pc_o, e.pc);
        end
        checks++;
        if (dutFlags() !== e.flags) begin
            errors++;
            $display("[TB] FAIL row %0d flags{fetch,we,re,wr,busy,done,err} got %b expected %b",
                     e.idx, dutFlags(), e.flags);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; start_i = 1'b0; op_i = 4'd0; halt_i = 1'b0;
        zero_i = 1'b0; target_i = '0; mem_ack_i = 1'b0;

        // Reset, start, ADD/ADD/halt with a stray start mid-program
        row(1, 1, OP_ADD, 0, 0, 10'h000, 0, 10'h000, 7'b0);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h000, 7'b0);
        row(0, 1, OP_ADD, 0, 0, 10'h000, 0, 10'h000, 7'b0);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h000, F_FETCH | F_BUSY);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h000, F_WE | F_BUSY);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h001, F_FETCH | F_BUSY);
        row(0, 1, OP_ADD, 0, 0, 10'h000, 0, 10'h001, F_WE | F_BUSY);
        row(0, 1, OP_ADD, 0, 0, 10'h000, 0, 10'h002, F_FETCH | F_BUSY);
        row(0, 0, OP_ADD, 1, 0, 10'h000, 0, 10'h002, F_BUSY);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h002, F_DONE);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h002, F_DONE);
        row(0, 1, OP_ADD, 0, 0, 10'h000, 0, 10'h002, F_DONE);
        // Branches: BZ taken/untaken, BNZ taken/untaken, JMP to the top of memory
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h000, F_FETCH | F_BUSY);
        row(0, 0, OP_BZ,  0, 1, 10'h005, 0, 10'h000, F_BUSY);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h005, F_FETCH | F_BUSY);
        row(0, 0, OP_BZ,  0, 0, 10'h009, 0, 10'h005, F_BUSY);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h006, F_FETCH | F_BUSY);
        row(0, 0, OP_BNZ, 0, 0, 10'h020, 0, 10'h006, F_BUSY);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h020, F_FETCH | F_BUSY);
        row(0, 0, OP_BNZ, 0, 1, 10'h030, 0, 10'h020, F_BUSY);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h021, F_FETCH | F_BUSY);
        row(0, 0, OP_JMP, 0, 1, 10'h3FF, 0, 10'h021, F_BUSY);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h3FF, F_FETCH | F_BUSY);
        // ADD at 0x3FF wraps the PC to zero
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h3FF, F_WE | F_BUSY);
        // LD with a stray ack outside MEM, then three wait cycles and an ack
        row(0, 0, OP_ADD, 0, 0, 10'h000, 1, 10'h000, F_FETCH | F_BUSY);
        row(0, 0, OP_LD,  0, 0, 10'h000, 1, 10'h000, F_BUSY);
        for (int i = 0; i < 3; i++)
            row(0, 0, OP_LD, 0, 0, 10'h000, 0, 10'h000, F_RE | F_BUSY);
        row(0, 0, OP_LD,  0, 0, 10'h000, 1, 10'h000, F_RE | F_WE | F_BUSY);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h001, F_FETCH | F_BUSY);
        // ST that never gets acked: 15 request cycles, then error stop
        row(0, 0, OP_ST,  0, 0, 10'h000, 0, 10'h001, F_BUSY);
        for (int i = 0; i < 15; i++)
            row(0, (i == 4) ? 1'b1 : 1'b0, OP_ST, 0, 0, 10'h000, 0, 10'h001, F_WR | F_BUSY);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h001, F_DONE | F_ERR);
        row(0, 1, OP_ADD, 0, 0, 10'h000, 0, 10'h001, F_DONE | F_ERR);
        // Restart, then reset in the middle of a load
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h000, F_FETCH | F_BUSY);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h000, F_WE | F_BUSY);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h001, F_FETCH | F_BUSY);
        row(0, 0, OP_LD,  0, 0, 10'h000, 0, 10'h001, F_BUSY);
        row(1, 1, OP_LD,  0, 0, 10'h000, 0, 10'h001, F_RE | F_BUSY);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h000, 7'b0);
        row(0, 1, OP_ADD, 0, 0, 10'h000, 0, 10'h000, 7'b0);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h000, F_FETCH | F_BUSY);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h000, F_WE | F_BUSY);
        row(0, 0, OP_ADD, 0, 0, 10'h000, 0, 10'h001, F_FETCH | F_BUSY);

        repeat (2) @(posedge CLK);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i);
            checkOutput();
        end
        checkValue("scoreboard_drained", expQ.size(), 0);

        // Hand-written: ST timeout measured by counting request cycles (currently in EXEC)
        @(negedge CLK);
        reset = 1'b0; start_i = 1'b0; op_i = 4'(OP_ST); halt_i = 1'b0; mem_ack_i = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            #2;
            if (!mem_we_o) break;
            n++;
        end
        checkValue("st_timeout_we_cycles", n, 15);
        checkValue("st_timeout_err", int'(err_o), 1);
        checkValue("st_timeout_done", int'(done_o), 1);
        checkValue("st_timeout_busy", int'(busy_o), 0);

        // Hand-written: LD acked on the last allowed wait cycle is still accepted
        @(negedge CLK); start_i = 1'b1;
        @(negedge CLK); start_i = 1'b0;
        @(negedge CLK); op_i = 4'(OP_LD);
        for (int i = 1; i <= 15; i++) begin
            @(negedge CLK);
            mem_ack_i = (i == 15);
            #2;
            if (i == 15) begin
                checkValue("late_ack_reg_we", int'(reg_we_o), 1);
                checkValue("late_ack_re", int'(mem_re_o), 1);
                checkValue("late_ack_err", int'(err_o), 0);
            end
        end
        @(negedge CLK);
        mem_ack_i = 1'b0;
        #2;
        checkValue("late_ack_pc", int'(pc_o), 1);
        checkValue("late_ack_re_dropped", int'(mem_re_o), 0);
        checkValue("late_ack_fetch", int'(fetch_o), 1);
        checkValue("late_ack_no_err", int'(err_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
